// File: rtl/pipe_pkg.sv
// Shared pipeline encodings for the RV32I datapath: writeback source select
// codes, load funct3 encodings and register-address width.
package pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [1:0] wb_sel_t;

  localparam wb_sel_t WB_SEL_ALU  = 2'b00;
  localparam wb_sel_t WB_SEL_LOAD = 2'b01;
  localparam wb_sel_t WB_SEL_PC4  = 2'b10;
  localparam wb_sel_t WB_SEL_RSV  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// load_align: purely combinational load data extraction and extension.
// Ports:
//   funct3  - RV32I load encoding (LB/LH/LW/LBU/LHU)
//   offset  - byte offset within the word (address bits [1:0])
//   word    - raw aligned 32-bit word from data memory
//   result  - aligned, sign-/zero-extended load value
// Halfword loads use offset[1] only; offset[0] is ignored (no misalign trap).
// Undefined funct3 encodings pass the full word through unshifted.
module load_align
  import pipe_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte and halfword lane pick
  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
  end

  // Extension per load type
  always_comb begin
    result = word;
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'd0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'd0, half_sel};
      F3_LW:   result = word;
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register plus writeback source selection.
// Captures MEM-stage results each cycle and drives the register file write
// port one cycle later. Update priority: rst > flush > stall > load.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   mem_*               - MEM-stage instruction fields and data
//   stall, flush        - hazard unit controls (flush wins over stall)
//   wb_valid            - WB register holds a real instruction
//   wb_wr_en/addr/data  - register file write port
//   instret             - 64-bit retired count (only with MEM_WB_INSTRET_EN)
// Optional feature macro: MEM_WB_INSTRET_EN adds the instret port and counter.
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_reg_wr,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic [1:0]            mem_wb_sel,
  input  logic [2:0]            mem_funct3,
  input  logic [XLEN-1:0]       mem_alu_result,
  input  logic [XLEN-1:0]       mem_load_data,
  input  logic [XLEN-1:0]       mem_pc_plus4,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  wb_valid,
  output logic                  wb_wr_en,
  output logic [REG_ADDR_W-1:0] wb_wr_addr,
  output logic [XLEN-1:0]       wb_wr_data
`ifdef MEM_WB_INSTRET_EN
  ,
  output logic [63:0]           instret
`endif
);

  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] next_data;
  logic            next_wr_en;
  logic            load_en;

  load_align u_load_align (
    .funct3 (mem_funct3),
    .offset (mem_alu_result[1:0]),
    .word   (mem_load_data),
    .result (load_val)
  );

  // Writeback source select
  always_comb begin
    next_data = '0;
    case (wb_sel_t'(mem_wb_sel))
      WB_SEL_ALU:  next_data = mem_alu_result;
      WB_SEL_LOAD: next_data = load_val;
      WB_SEL_PC4:  next_data = mem_pc_plus4;
      WB_SEL_RSV:  next_data = '0;
      default:     next_data = '0;
    endcase
  end

  // x0 is hardwired zero, so it never gets a write strobe
  assign next_wr_en = mem_valid & mem_reg_wr & (mem_rd_addr != REG_ADDR_W'(0));
  assign load_en    = ~flush & ~stall;

  // WB pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_wr_en   <= 1'b0;
      wb_wr_addr <= '0;
      wb_wr_data <= '0;
    end else if (flush) begin
      wb_valid   <= 1'b0;
      wb_wr_en   <= 1'b0;
      wb_wr_addr <= '0;
      wb_wr_data <= '0;
    end else if (load_en) begin
      wb_valid   <= mem_valid;
      wb_wr_en   <= next_wr_en;
      wb_wr_addr <= mem_rd_addr;
      wb_wr_data <= next_data;
    end
  end

`ifdef MEM_WB_INSTRET_EN
  // Retired-instruction counter; wraps naturally at 2^64
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= 64'd0;
    end else if (load_en && mem_valid) begin
      instret <= instret + 64'd1;
    end
  end
`endif

endmodule
